// File: rtl/atm_session_ctrl.sv
// ATM session controller: PIN check with attempt limit and inactivity timeout, then withdrawals.
// Optional card lockout after attempt exhaustion is enabled by `define ATM_LOCKOUT_EN.
module atm_session_ctrl #(
   parameter int PIN_W       = 4,
   parameter int BAL_W       = 8,
   parameter int MAX_TRIES   = 3,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               card_in,
   input  logic [BAL_W-1:0]                   balance_in,
   input  logic [PIN_W-1:0]                   card_pin,
   input  logic                               pin_valid,
   input  logic [PIN_W-1:0]                   pin_in,
   input  logic                               amount_valid,
   input  logic [BAL_W-1:0]                   amount,
   input  logic                               cancel,
   output logic                               auth_ok,
   output logic [BAL_W-1:0]                   balance,
   output logic                               dispense,
   output logic                               insufficient,
   output logic                               card_eject,
   output logic                               eject_tries,
   output logic                               eject_timeout,
   output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
   output logic [$clog2(TIMEOUT_CYC+1)-1:0]   time_left,
   output logic                               locked
);

   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int TIME_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WAIT_PIN = 2'd1;
   localparam logic [1:0] S_AUTH     = 2'd2;
   localparam logic [1:0] S_EJECT    = 2'd3;

   localparam logic [TRY_W-1:0]  TRIES_INIT = TRY_W'(MAX_TRIES);
   localparam logic [TRY_W-1:0]  TRY_ONE    = TRY_W'(1);
   localparam logic [TIME_W-1:0] TIME_INIT  = TIME_W'(TIMEOUT_CYC);
   localparam logic [TIME_W-1:0] TIME_ONE   = TIME_W'(1);

   logic [1:0]        state_q, state_d;
   logic [BAL_W-1:0]  balance_q, balance_d;
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic [TIME_W-1:0] time_q, time_d;
   logic              auth_ok_q, card_eject_q;
   logic              dispense_q, dispense_d;
   logic              insufficient_q, insufficient_d;
   logic              eject_tries_q, eject_tries_d;
   logic              eject_timeout_q, eject_timeout_d;
   logic              locked_q, locked_d;

   // Next-state, counter and pulse computation
   always_comb begin
      state_d         = state_q;
      balance_d       = balance_q;
      tries_d         = tries_q;
      time_d          = time_q;
      dispense_d      = 1'b0;
      insufficient_d  = 1'b0;
      eject_tries_d   = 1'b0;
      eject_timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (card_in && !locked_q) begin
               state_d   = S_WAIT_PIN;
               balance_d = balance_in;
               tries_d   = TRIES_INIT;
               time_d    = TIME_INIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_PIN: begin
            if (!card_in) begin
               state_d   = S_IDLE;
               balance_d = {BAL_W{1'b0}};
               tries_d   = {TRY_W{1'b0}};
               time_d    = {TIME_W{1'b0}};
            end else if (pin_valid) begin
               // A strobe in the expiry cycle wins over the timeout
               time_d = TIME_INIT;
               if (pin_in == card_pin) begin
                  state_d = S_AUTH;
               end else begin
                  tries_d = tries_q - TRY_ONE;
                  if (tries_q == TRY_ONE) begin
                     state_d       = S_EJECT;
                     eject_tries_d = 1'b1;
                  end else begin
                     state_d = S_WAIT_PIN;
                  end
               end
            end else if (time_q == TIME_ONE) begin
               state_d         = S_EJECT;
               eject_timeout_d = 1'b1;
               time_d          = {TIME_W{1'b0}};
            end else begin
               time_d = time_q - TIME_ONE;
            end
         end
         S_AUTH: begin
            if (!card_in) begin
               state_d   = S_IDLE;
               balance_d = {BAL_W{1'b0}};
               tries_d   = {TRY_W{1'b0}};
               time_d    = {TIME_W{1'b0}};
            end else if (cancel) begin
               state_d = S_EJECT;
            end else if (amount_valid) begin
               time_d = TIME_INIT;
               if (amount <= balance_q) begin
                  balance_d  = balance_q - amount;
                  dispense_d = 1'b1;
               end else begin
                  insufficient_d = 1'b1;
               end
            end else if (time_q == TIME_ONE) begin
               state_d         = S_EJECT;
               eject_timeout_d = 1'b1;
               time_d          = {TIME_W{1'b0}};
            end else begin
               time_d = time_q - TIME_ONE;
            end
         end
         S_EJECT: begin
            if (!card_in) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_EJECT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
`ifdef ATM_LOCKOUT_EN
      locked_d = locked_q | eject_tries_d;
`else
      locked_d = 1'b0;
`endif
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         balance_q       <= {BAL_W{1'b0}};
         tries_q         <= {TRY_W{1'b0}};
         time_q          <= {TIME_W{1'b0}};
         auth_ok_q       <= 1'b0;
         card_eject_q    <= 1'b0;
         dispense_q      <= 1'b0;
         insufficient_q  <= 1'b0;
         eject_tries_q   <= 1'b0;
         eject_timeout_q <= 1'b0;
         locked_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         balance_q       <= balance_d;
         tries_q         <= tries_d;
         time_q          <= time_d;
         auth_ok_q       <= (state_d == S_AUTH);
         card_eject_q    <= (state_d == S_EJECT);
         dispense_q      <= dispense_d;
         insufficient_q  <= insufficient_d;
         eject_tries_q   <= eject_tries_d;
         eject_timeout_q <= eject_timeout_d;
         locked_q        <= locked_d;
      end
   end

   assign auth_ok       = auth_ok_q;
   assign balance       = balance_q;
   assign dispense      = dispense_q;
   assign insufficient  = insufficient_q;
   assign card_eject    = card_eject_q;
   assign eject_tries   = eject_tries_q;
   assign eject_timeout = eject_timeout_q;
   assign tries_left    = tries_q;
   assign time_left     = time_q;
   assign locked        = locked_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Table-driven bench for atm_session_ctrl with a scoreboard queue of expected output records.
module tb_atm_session_ctrl;

   localparam int PIN_W = 4, BAL_W = 8, MAX_TRIES = 3, TIMEOUT_CYC = 16;
`ifdef ATM_LOCKOUT_EN
   localparam logic LOCK_EN = 1'b1;
`else
   localparam logic LOCK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic card_in = 1'b0, pin_valid = 1'b0, amount_valid = 1'b0, cancel = 1'b0;
   logic [BAL_W-1:0] balance_in = 8'd100, amount = 8'd0;
   logic [PIN_W-1:0] card_pin = 4'd5, pin_in = 4'd0;
   logic auth_ok, dispense, insufficient, card_eject, eject_tries, eject_timeout, locked;
   logic [BAL_W-1:0] balance;
   logic [1:0] tries_left;
   logic [4:0] time_left;

   atm_session_ctrl #(.PIN_W(PIN_W), .BAL_W(BAL_W), .MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .card_in(card_in), .balance_in(balance_in), .card_pin(card_pin),
      .pin_valid(pin_valid), .pin_in(pin_in), .amount_valid(amount_valid), .amount(amount),
      .cancel(cancel), .auth_ok(auth_ok), .balance(balance), .dispense(dispense),
      .insufficient(insufficient), .card_eject(card_eject), .eject_tries(eject_tries),
      .eject_timeout(eject_timeout), .tries_left(tries_left), .time_left(time_left), .locked(locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ci; logic pv; logic [3:0] pin; logic av; logic [7:0] amt; logic cn;
      logic e_auth; logic [7:0] e_bal; logic e_disp; logic e_ins; logic e_ej;
      logic e_etr; logic e_eto; logic [1:0] e_tries; logic [4:0] e_time; logic chk_ctr; logic e_lock;
   } vec_t;

   vec_t sb_q[$];
   vec_t tbl[21];
   int checks = 0;
   int errors = 0;

   function automatic vec_t r(input logic ci, input logic pv, input logic [3:0] pin, input logic av,
                              input logic [7:0] amt, input logic cn, input logic e_auth,
                              input logic [7:0] e_bal, input logic e_disp, input logic e_ins,
                              input logic e_ej, input logic e_etr, input logic e_eto,
                              input logic [1:0] e_tries, input logic [4:0] e_time,
                              input logic chk_ctr, input logic e_lock);
      vec_t v;
      v.ci = ci; v.pv = pv; v.pin = pin; v.av = av; v.amt = amt; v.cn = cn;
      v.e_auth = e_auth; v.e_bal = e_bal; v.e_disp = e_disp; v.e_ins = e_ins; v.e_ej = e_ej;
      v.e_etr = e_etr; v.e_eto = e_eto; v.e_tries = e_tries; v.e_time = e_time;
      v.chk_ctr = chk_ctr; v.e_lock = e_lock;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".auth_ok"}, {31'd0, auth_ok}, 32'd0);
      chk({tag, ".balance"}, {24'd0, balance}, 32'd0);
      chk({tag, ".dispense"}, {31'd0, dispense}, 32'd0);
      chk({tag, ".insufficient"}, {31'd0, insufficient}, 32'd0);
      chk({tag, ".card_eject"}, {31'd0, card_eject}, 32'd0);
      chk({tag, ".eject_tries"}, {31'd0, eject_tries}, 32'd0);
      chk({tag, ".eject_timeout"}, {31'd0, eject_timeout}, 32'd0);
      chk({tag, ".tries_left"}, {30'd0, tries_left}, 32'd0);
      chk({tag, ".time_left"}, {27'd0, time_left}, 32'd0);
      chk({tag, ".locked"}, {31'd0, locked}, 32'd0);
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge
   task automatic step(input vec_t v, input string tag);
      vec_t e;
      card_in = v.ci; pin_valid = v.pv; pin_in = v.pin;
      amount_valid = v.av; amount = v.amt; cancel = v.cn;
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb_q.pop_front();
         chk({tag, ".auth_ok"}, {31'd0, auth_ok}, {31'd0, e.e_auth});
         chk({tag, ".balance"}, {24'd0, balance}, {24'd0, e.e_bal});
         chk({tag, ".dispense"}, {31'd0, dispense}, {31'd0, e.e_disp});
         chk({tag, ".insufficient"}, {31'd0, insufficient}, {31'd0, e.e_ins});
         chk({tag, ".card_eject"}, {31'd0, card_eject}, {31'd0, e.e_ej});
         chk({tag, ".eject_tries"}, {31'd0, eject_tries}, {31'd0, e.e_etr});
         chk({tag, ".eject_timeout"}, {31'd0, eject_timeout}, {31'd0, e.e_eto});
         chk({tag, ".locked"}, {31'd0, locked}, {31'd0, e.e_lock});
         if (e.chk_ctr) begin
            chk({tag, ".tries_left"}, {30'd0, tries_left}, {30'd0, e.e_tries});
            chk({tag, ".time_left"}, {27'd0, time_left}, {27'd0, e.e_time});
         end
      end
   endtask

   initial begin
      // ci pv pin av amt cn | auth bal disp ins ej etr eto tries time chk lock
      tbl[0]  = r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0);
      tbl[1]  = r(1'b1, 1'b1, 4'd5, 1'b0, 8'd0,  1'b0, 1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0);
      tbl[2]  = r(1'b1, 1'b0, 4'd0, 1'b1, 8'd30, 1'b0, 1'b1, 8'd70,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0);
      tbl[3]  = r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b1, 8'd70,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd15, 1'b1, 1'b0);
      tbl[4]  = r(1'b1, 1'b0, 4'd0, 1'b1, 8'd71, 1'b0, 1'b1, 8'd70,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0);
      tbl[5]  = r(1'b1, 1'b0, 4'd0, 1'b1, 8'd70, 1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0);
      tbl[6]  = r(1'b1, 1'b1, 4'd3, 1'b1, 8'd0,  1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0);
      tbl[7]  = r(1'b1, 1'b0, 4'd0, 1'b1, 8'd5,  1'b0, 1'b1, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0);
      tbl[8]  = r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0,  1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 5'd16, 1'b0, 1'b0);
      tbl[9]  = r(1'b1, 1'b0, 4'd0, 1'b1, 8'd0,  1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 5'd16, 1'b0, 1'b0);
      tbl[10] = r(1'b0, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b0, 1'b0);
      tbl[11] = r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0);
      tbl[12] = r(1'b1, 1'b1, 4'd3, 1'b0, 8'd0,  1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd16, 1'b1, 1'b0);
      tbl[13] = r(1'b1, 1'b0, 4'd0, 1'b1, 8'd9,  1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd15, 1'b1, 1'b0);
      tbl[14] = r(1'b1, 1'b1, 4'd3, 1'b0, 8'd0,  1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 5'd16, 1'b1, 1'b0);
      tbl[15] = r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 5'd15, 1'b1, 1'b0);
      tbl[16] = r(1'b1, 1'b1, 4'd3, 1'b0, 8'd0,  1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd16, 1'b1, LOCK_EN);
      tbl[17] = r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd16, 1'b0, LOCK_EN);
      tbl[18] = r(1'b0, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd16, 1'b0, LOCK_EN);
      tbl[19] = r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, !LOCK_EN, LOCK_EN);
      tbl[20] = r(1'b0, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, LOCK_EN ? 8'd100 : 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, LOCK_EN);

      #1;
      chk_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("post_reset");

      for (int i = 0; i < 21; i++) begin
         step(tbl[i], $sformatf("tbl%0d", i));
      end

      // Cancel beats amount; card pull from AUTH clears balance
      rst_n = 1'b0;
      #1;
      chk_zero("reset2");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      balance_in = 8'd50;
      step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0), "t5_ins");
      step(r(1'b1, 1'b1, 4'd5, 1'b0, 8'd0,  1'b0, 1'b1, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0), "t5_pin");
      step(r(1'b1, 1'b0, 4'd0, 1'b1, 8'd10, 1'b1, 1'b0, 8'd50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 5'd16, 1'b0, 1'b0), "t5_cancel");
      step(r(1'b0, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b0, 1'b0), "t5_out");
      step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0), "pull_ins");
      step(r(1'b1, 1'b1, 4'd5, 1'b0, 8'd0,  1'b0, 1'b1, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0), "pull_pin");
      step(r(1'b0, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0,  1'b0, 1'b0), "pull_out");
      step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0), "t6_ins");
      step(r(1'b1, 1'b1, 4'd5, 1'b0, 8'd0,  1'b0, 1'b1, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0), "t6_pin");

      // Asynchronous reset in the middle of AUTH
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("t6_async");
      card_in = 1'b0; pin_valid = 1'b0; amount_valid = 1'b0; cancel = 1'b0;
      @(posedge clk);
      #1;
      chk_zero("t6_held");
      @(negedge clk);
      rst_n = 1'b1;
      step(r(1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0,  1'b1, 1'b0), "t6_idle");

      // Timeout in WAIT_PIN
      step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0), "t4_ins");
      for (int k = 1; k <= 15; k++) begin
         step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'(16 - k), 1'b1, 1'b0),
              $sformatf("t4_wait%0d", k));
      end
      step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 5'd0, 1'b1, 1'b0), "t4_expire");
      step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 5'd0, 1'b0, 1'b0), "t4_hold");
      step(r(1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd0, 1'b0, 1'b0), "t4_out");

      // Strobe on the expiry cycle is processed instead of timing out
      step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd16, 1'b1, 1'b0), "t4b_ins");
      for (int k = 1; k <= 15; k++) begin
         step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'(16 - k), 1'b1, 1'b0),
              $sformatf("t4b_wait%0d", k));
      end
      step(r(1'b1, 1'b1, 4'd3, 1'b0, 8'd0, 1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd16, 1'b1, 1'b0), "t4b_edge");

      // Timeout in AUTH
      step(r(1'b1, 1'b1, 4'd5, 1'b0, 8'd0, 1'b0, 1'b1, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd16, 1'b1, 1'b0), "t4c_pin");
      for (int k = 1; k <= 15; k++) begin
         step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 5'(16 - k), 1'b1, 1'b0),
              $sformatf("t4c_wait%0d", k));
      end
      step(r(1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 5'd0, 1'b1, 1'b0), "t4c_expire");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
